// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the IF fetch port
// (read-only) and the MEM data port (read/write).
// Ports:
//   clk_i, rst_i (async, active-low)
//   if_*   : IF request in, read data and ready pulse out
//   mem_*  : MEM request, we, addr, wdata in; read data and ready pulse out
//   stall_o: pipeline freeze while any request is outstanding
//   err_o  : pulses with ready when the RAM never acknowledged
//   ram_*  : held request towards the RAM, single-cycle ack back
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [31:0]   if_rdata_o,
    output logic          if_ready_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [31:0]   mem_wdata_i,
    output logic [31:0]   mem_rdata_o,
    output logic          mem_ready_o,
    output logic          stall_o,
    output logic          err_o,
    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i,
    input  logic          ram_ack_i
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_MEM,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q;
    logic [TW-1:0]   tmo_q;
    logic            owner_mem_q;
    logic            err_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [31:0]     ram_wdata_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     mem_rdata_q;

    logic idle, busy, gnt_if, gnt_mem, ack_hit, tmo_hit;

    assign idle = (state_q == S_IDLE);
    assign busy = (state_q == S_BUSY_IF) || (state_q == S_BUSY_MEM);

    // IF only beats a pending MEM request once it has been passed over
    // MAX_STARVE times in a row.
    assign gnt_if  = idle && if_req_i &&
                     (!mem_req_i || (starve_q == STARVE_MAX));
    assign gnt_mem = idle && mem_req_i && !gnt_if;

    // An ack on the last watchdog cycle still counts as a normal completion.
    assign ack_hit = busy && ram_ack_i;
    assign tmo_hit = busy && !ram_ack_i && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_mem) begin
                    state_d = S_BUSY_MEM;
                end else if (gnt_if) begin
                    state_d = S_BUSY_IF;
                end
            end
            S_BUSY_IF, S_BUSY_MEM: begin
                if (ack_hit || tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant latch, watchdog, starvation counter and read-data capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_q    <= '0;
            tmo_q       <= '0;
            owner_mem_q <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (gnt_mem) begin
                owner_mem_q <= 1'b1;
                err_q       <= 1'b0;
                tmo_q       <= '0;
                ram_we_q    <= mem_we_i;
                ram_addr_q  <= mem_addr_i;
                ram_wdata_q <= mem_wdata_i;
                if (if_req_i && (starve_q != STARVE_MAX)) begin
                    starve_q <= starve_q + SW'(1);
                end
            end else if (gnt_if) begin
                owner_mem_q <= 1'b0;
                err_q       <= 1'b0;
                tmo_q       <= '0;
                ram_we_q    <= 1'b0;
                ram_addr_q  <= if_addr_i;
                ram_wdata_q <= '0;
                starve_q    <= '0;
            end
            if (busy) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (ack_hit && !ram_we_q) begin
                if (owner_mem_q) begin
                    mem_rdata_q <= ram_rdata_i;
                end else begin
                    if_rdata_q <= ram_rdata_i;
                end
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
                if (!ram_we_q) begin
                    if (owner_mem_q) begin
                        mem_rdata_q <= 32'hDEADBEEF;
                    end else begin
                        if_rdata_q <= 32'hDEADBEEF;
                    end
                end
            end
        end
    end

    // Output logic
    always_comb begin
        ram_req_o   = busy;
        ram_we_o    = busy && ram_we_q;
        ram_addr_o  = ram_addr_q;
        ram_wdata_o = ram_wdata_q;
        if_rdata_o  = if_rdata_q;
        mem_rdata_o = mem_rdata_q;
        if_ready_o  = (state_q == S_DONE) && !owner_mem_q;
        mem_ready_o = (state_q == S_DONE) && owner_mem_q;
        err_o       = (state_q == S_DONE) && err_q;
        // Gated by reset so every output reads 0 while reset is held.
        stall_o     = rst_i &&
                      ((if_req_i && !if_ready_o) ||
                       (mem_req_i && !mem_ready_o));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Drives the RAM side by hand and checks every step against fixed values.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        stall_o;
    logic        err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_ack_i;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .AW(32), .MAX_STARVE(4), .TIMEOUT(64)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ready_o (if_ready_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o),
        .stall_o    (stall_o),
        .err_o      (err_o),
        .ram_req_o  (ram_req_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .ram_ack_i  (ram_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int mem_grants;
        int req_cycles;
        bit if_seen;
        bit prev_req;
        bit err_early;
        bit got_ready;

        rst_i       = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        ram_rdata_i = '0;
        ram_ack_i   = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_ramreq", ram_req_o, 0);

        // Reset in the middle of a MEM access
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h44;
        step();
        #1;
        chk("t1_busy_req", ram_req_o, 1);
        chk("t1_busy_addr", ram_addr_o, 32'h44);
        rst_i = 1'b0;
        #1;
        chk("t1_rst_req", ram_req_o, 0);
        chk("t1_rst_addr", ram_addr_o, 0);
        chk("t1_rst_stall", stall_o, 0);
        chk("t1_rst_ready", {mem_ready_o, if_ready_o, err_o}, 0);
        mem_req_i = 1'b0;
        step();
        rst_i = 1'b1;
        // Stray ack while idle must be ignored
        ram_ack_i = 1'b1;
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t1_idle_req", ram_req_o, 0);
        chk("t1_idle_ready", {mem_ready_o, if_ready_o}, 0);
        step();
        #1;
        chk("t1_idle_stall", stall_o, 0);
        chk("t1_idle_ready2", {mem_ready_o, if_ready_o}, 0);
        chk("t1_idle_rdata", mem_rdata_o, 0);

        // IF read, ack one cycle after ram_req_o
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        #1;
        chk("t2_stall_idle", stall_o, 1);
        step();
        #1;
        chk("t2_req", ram_req_o, 1);
        chk("t2_addr", ram_addr_o, 32'h10);
        chk("t2_we0", ram_we_o, 0);
        step();
        ram_ack_i   = 1'b1;
        ram_rdata_i = 32'h8C010004;
        #1;
        chk("t2_req_hold", ram_req_o, 1);
        chk("t2_we1", ram_we_o, 0);
        chk("t2_noready", if_ready_o, 0);
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t2_ready", if_ready_o, 1);
        chk("t2_rdata", if_rdata_o, 32'h8C010004);
        chk("t2_req_drop", ram_req_o, 0);
        chk("t2_err", err_o, 0);
        chk("t2_mready", mem_ready_o, 0);
        if_req_i = 1'b0;
        step();
        #1;
        chk("t2_ready_pulse", if_ready_o, 0);
        chk("t2_rdata_hold", if_rdata_o, 32'h8C010004);

        // Simultaneous IF and MEM read: MEM first
        if_req_i   = 1'b1;
        if_addr_i  = 32'h14;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h40;
        step();
        ram_ack_i   = 1'b1;
        ram_rdata_i = 32'h11112222;
        #1;
        chk("t3_mem_first", ram_addr_o, 32'h40);
        chk("t3_stall_a", stall_o, 1);
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t3_mready", mem_ready_o, 1);
        chk("t3_mrdata", mem_rdata_o, 32'h11112222);
        chk("t3_stall_b", stall_o, 1);
        mem_req_i = 1'b0;
        step();
        #1;
        chk("t3_idle_req", ram_req_o, 0);
        chk("t3_stall_c", stall_o, 1);
        step();
        ram_ack_i   = 1'b1;
        ram_rdata_i = 32'h33334444;
        #1;
        chk("t3_if_addr", ram_addr_o, 32'h14);
        chk("t3_stall_d", stall_o, 1);
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t3_iready", if_ready_o, 1);
        chk("t3_irdata", if_rdata_o, 32'h33334444);
        chk("t3_stall_e", stall_o, 0);
        if_req_i = 1'b0;
        step();

        // Starvation: IF held while MEM keeps requesting
        if_req_i    = 1'b1;
        if_addr_i   = 32'h18;
        mem_req_i   = 1'b1;
        mem_addr_i  = 32'h80;
        ram_rdata_i = 32'hAAAA0000;
        mem_grants  = 0;
        if_seen     = 1'b0;
        prev_req    = 1'b0;
        for (int i = 0; i < 60 && !if_seen; i++) begin
            step();
            ram_ack_i = ram_req_o;
            if (ram_req_o && !prev_req) begin
                if (ram_addr_o == 32'h80) mem_grants++;
                else if (ram_addr_o == 32'h18) if_seen = 1'b1;
            end
            prev_req = ram_req_o;
        end
        chk("t4_if_granted", {31'd0, if_seen}, 1);
        chk("t4_mem_grants", mem_grants, 4);
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t4_iready", if_ready_o, 1);
        chk("t4_starve", {29'd0, dut.starve_q}, 0);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        step();

        // MEM write
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h20;
        mem_wdata_i = 32'h5;
        ram_rdata_i = 32'h99999999;
        step();
        ram_ack_i = 1'b1;
        #1;
        chk("t5_we", ram_we_o, 1);
        chk("t5_wdata", ram_wdata_o, 32'h5);
        chk("t5_addr", ram_addr_o, 32'h20);
        step();
        ram_ack_i = 1'b0;
        #1;
        chk("t5_mready", mem_ready_o, 1);
        chk("t5_mrdata", mem_rdata_o, 32'hAAAA0000);
        chk("t5_err", err_o, 0);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        step();

        // Timeout on an IF read
        if_req_i   = 1'b1;
        if_addr_i  = 32'h24;
        req_cycles = 0;
        err_early  = 1'b0;
        got_ready  = 1'b0;
        for (int i = 0; i < 100 && !got_ready; i++) begin
            step();
            if (ram_req_o) req_cycles++;
            if (if_ready_o) got_ready = 1'b1;
            else if (err_o) err_early = 1'b1;
        end
        chk("t6_ready", {31'd0, got_ready}, 1);
        chk("t6_req_cycles", req_cycles, 64);
        chk("t6_err", err_o, 1);
        chk("t6_err_early", {31'd0, err_early}, 0);
        chk("t6_rdata", if_rdata_o, 32'hDEADBEEF);
        if_req_i = 1'b0;
        step();
        #1;
        chk("t6_err_pulse", err_o, 0);
        chk("t6_ready_pulse", if_ready_o, 0);
        chk("t6_stall", stall_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
